// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state;
    logic [4:0] cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0] ma, mb;
    logic sa, sb, is_div;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0] madd, diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, mul_res;
    logic [XLEN-1:0] res_hi, res_lo;
    logic div0;
    assign abs_a = (op[0] && A[XLEN-1]) ? -A : A;
    assign abs_b = (op[0] && B[XLEN-1]) ? -B : B;
    // Multiply: acc = {partial product, remaining multiplier bits}; ma is the multiplicand
    assign madd = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, ma};
    assign mul_nxt = acc[0] ? {madd, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    // Divide: acc = {partial remainder, dividend/quotient bits}; mb is the divisor
    assign diff = acc[2*XLEN-1:XLEN-1] - {1'b0, mb};
    assign div_nxt = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign div0 = is_div && (mb == '0);
    assign mul_res = (sa ^ sb) ? -acc : acc;
    // Divide by zero leaves the raw quotient of all ones and returns the original dividend
    assign res_lo = !is_div ? mul_res[XLEN-1:0] : div0 ? '1
                  : (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign res_hi = !is_div ? mul_res[2*XLEN-1:XLEN] : div0 ? (sa ? -ma : ma)
                  : sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            ma     <= '0;
            mb     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            is_div <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        sa     <= op[0] & A[XLEN-1];
                        sb     <= op[0] & B[XLEN-1];
                        ma     <= abs_a;
                        mb     <= abs_b;
                        acc    <= {{XLEN{1'b0}}, op[1] ? abs_a : abs_b};
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ITER;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                ITER: begin
                    acc <= is_div ? div_nxt : mul_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(XLEN-1)) state <= FIX;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
